// File: rtl/pulse_ctrl_pkg.sv
// Shared types and default widths for the pulse_ctrl fractional pulse divider.
// Optional feature macro: PULSE_CTRL_AUTORELOAD_EN (see pulse_ctrl.sv).
package pulse_ctrl_pkg;

    localparam int DEF_ACC_W = 16;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/pulse_acc.sv
// Phase accumulator: adds a run-time increment to the fraction each enabled cycle;
// the registered carry out of the fraction is the output pulse.
module pulse_acc
    import pulse_ctrl_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [ACC_W:0]   i_incr,
    output logic             o_carry
);

    logic [ACC_W:0] acc_q;
    logic [ACC_W:0] acc_d;

    // NOTE: acc_d gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        acc_d = acc_q;
        if (i_clr) begin
            acc_d = '0;
        end else if (i_en) begin
            // Carry is dropped before adding, so it is high for exactly one cycle.
            acc_d = {1'b0, acc_q[ACC_W-1:0]} + i_incr;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign o_carry = acc_q[ACC_W];

endmodule

// File: rtl/pulse_ctrl.sv
// Run-time controller for the fractional pulse divider: config shadowing, start/stop, bursts.
// Define PULSE_CTRL_AUTORELOAD_EN to add i_auto (burst auto-reload without leaving RUN).
module pulse_ctrl
    import pulse_ctrl_pkg::*;
#(
    parameter int               ACC_W    = DEF_ACC_W,
    parameter int               CNT_W    = DEF_CNT_W,
    parameter logic [ACC_W:0]   DEF_INCR = (ACC_W+1)'(1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_cfg_valid,
    output logic               o_cfg_ready,
    input  logic [ACC_W:0]     i_cfg_incr,
    input  logic [CNT_W-1:0]   i_cfg_count,
    input  logic               i_start,
    input  logic               i_stop,
`ifdef PULSE_CTRL_AUTORELOAD_EN
    input  logic               i_auto,
`endif
    output logic               o_pulse,
    output logic               o_busy,
    output logic               o_done,
    output logic [CNT_W-1:0]   o_remaining
);

    state_e             state_q;
    logic [ACC_W:0]     incr_q;
    logic [CNT_W-1:0]   count_q;
    logic [ACC_W:0]     shadow_incr_q;
    logic [CNT_W-1:0]   shadow_count_q;
    logic               shadow_valid_q;
    logic [CNT_W-1:0]   remaining_q;
    logic               done_q;

    logic               cfg_ready;
    logic               cfg_fire;
    logic               start_go;
    logic               stop_go;
    logic               shadow_xfer;
    logic               last_pulse;
    logic               reload;
    logic               to_done;
    logic               acc_clr;
    logic               acc_en;
    logic [ACC_W:0]     acc_incr;
    logic [CNT_W-1:0]   reload_count;
    logic               auto_en;
    logic               pulse;

`ifdef PULSE_CTRL_AUTORELOAD_EN
    assign auto_en = i_auto;
`else
    assign auto_en = 1'b0;
`endif

    // While running, a second config must wait until the shadow has been consumed.
    assign cfg_ready = (state_q != ST_RUN) || !shadow_valid_q;

    always_comb begin
        cfg_fire     = i_cfg_valid && cfg_ready;
        start_go     = (state_q == ST_IDLE) && i_start && !i_stop;
        stop_go      = (state_q == ST_RUN) && i_stop;
        shadow_xfer  = (state_q == ST_RUN) && pulse && shadow_valid_q;
        last_pulse   = (state_q == ST_RUN) && !i_stop && pulse && (remaining_q == CNT_W'(1));
        reload       = last_pulse && auto_en;
        to_done      = last_pulse && !auto_en;
        acc_clr      = start_go || stop_go || to_done || (state_q == ST_DONE);
        acc_en       = (state_q == ST_RUN);
        // The accumulation that ends a pulse cycle already uses the shadowed rate.
        acc_incr     = shadow_xfer ? shadow_incr_q : incr_q;
        reload_count = shadow_xfer ? shadow_count_q : count_q;
    end

    pulse_acc #(
        .ACC_W   (ACC_W)
    ) u_acc (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (acc_clr),
        .i_en    (acc_en),
        .i_incr  (acc_incr),
        .o_carry (pulse)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= ST_IDLE;
            incr_q         <= DEF_INCR;
            count_q        <= '0;
            shadow_incr_q  <= '0;
            shadow_count_q <= '0;
            shadow_valid_q <= 1'b0;
            remaining_q    <= '0;
            done_q         <= 1'b0;
        end else begin
            done_q <= last_pulse;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_fire) begin
                        incr_q  <= i_cfg_incr;
                        count_q <= i_cfg_count;
                    end
                    if (start_go) begin
                        state_q     <= ST_RUN;
                        remaining_q <= cfg_fire ? i_cfg_count : count_q;
                    end
                end
                ST_RUN: begin
                    if (stop_go) begin
                        state_q        <= ST_IDLE;
                        remaining_q    <= '0;
                        shadow_valid_q <= 1'b0;
                        if (cfg_fire) begin
                            incr_q  <= i_cfg_incr;
                            count_q <= i_cfg_count;
                        end else if (shadow_valid_q) begin
                            incr_q  <= shadow_incr_q;
                            count_q <= shadow_count_q;
                        end
                    end else begin
                        if (shadow_xfer) begin
                            incr_q         <= shadow_incr_q;
                            count_q        <= shadow_count_q;
                            shadow_valid_q <= 1'b0;
                        end
                        if (cfg_fire) begin
                            shadow_incr_q  <= i_cfg_incr;
                            shadow_count_q <= i_cfg_count;
                            shadow_valid_q <= 1'b1;
                        end
                        // remaining == 0 while running means continuous mode.
                        if (reload) begin
                            remaining_q <= reload_count;
                        end else if (to_done) begin
                            state_q     <= ST_DONE;
                            remaining_q <= '0;
                        end else if (pulse && (remaining_q != '0)) begin
                            remaining_q <= remaining_q - CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_q        <= ST_IDLE;
                    shadow_valid_q <= 1'b0;
                    if (cfg_fire) begin
                        incr_q  <= i_cfg_incr;
                        count_q <= i_cfg_count;
                    end else if (shadow_valid_q) begin
                        incr_q  <= shadow_incr_q;
                        count_q <= shadow_count_q;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_cfg_ready = cfg_ready;
    assign o_pulse     = pulse;
    assign o_busy      = (state_q == ST_RUN);
    assign o_done      = done_q;
    assign o_remaining = remaining_q;

endmodule

// File: tb/tb_pulse_ctrl.sv
// Self-checking bench for pulse_ctrl (ACC_W=4): vector table plus pulse-time scoreboard;
// exercises auto-reload when PULSE_CTRL_AUTORELOAD_EN is defined.
module tb_pulse_ctrl;

    localparam int ACC_W = 4;
    localparam int CNT_W = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [ACC_W:0]     cfg_incr = '0;
    logic [CNT_W-1:0]   cfg_count = '0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               auto_i = 1'b0;
    logic               pulse;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   remaining;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulse_q [$];

    typedef struct {
        bit               use_cfg;
        logic [ACC_W:0]   incr;
        logic [CNT_W-1:0] count;
        int               win;
        int               np;
        int               off [8];
        int               done_off;
    } vec_t;

    vec_t vecs [7];
    vec_t v_def;
    vec_t v_shadow;

    pulse_ctrl #(
        .ACC_W       (ACC_W),
        .CNT_W       (CNT_W),
        .DEF_INCR    (5'd1)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cfg_valid (cfg_valid),
        .o_cfg_ready (cfg_ready),
        .i_cfg_incr  (cfg_incr),
        .i_cfg_count (cfg_count),
        .i_start     (start),
        .i_stop      (stop),
`ifdef PULSE_CTRL_AUTORELOAD_EN
        .i_auto      (auto_i),
`endif
        .o_pulse     (pulse),
        .o_busy      (busy),
        .o_done      (done),
        .o_remaining (remaining)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // One clock; every observed pulse is scored against the head of the expected queue.
    task automatic tick();
        int exp_c;
        @(posedge clk);
        #1;
        cyc++;
        if (pulse !== 1'b0) begin
            exp_c = (pulse_q.size() != 0) ? pulse_q[0] : -1;
            check("pulse_time", cyc, exp_c);
            if (pulse_q.size() != 0) void'(pulse_q.pop_front());
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int npre;
        if (v.use_cfg) begin
            cfg_valid = 1'b1;
            cfg_incr  = v.incr;
            cfg_count = v.count;
        end
        start = 1'b1;
        for (int i = 0; i < v.np; i++) pulse_q.push_back(cyc + 1 + v.off[i]);
        for (int k = 0; k <= v.win; k++) begin
            tick();
            if (k == 0) begin
                start     = 1'b0;
                cfg_valid = 1'b0;
            end
            npre = 0;
            for (int i = 0; i < v.np; i++) if (v.off[i] < k) npre++;
            check({name, "_busy"}, busy, (v.done_off < 0 || k < v.done_off));
            check({name, "_done"}, done, (k == v.done_off));
            check({name, "_rem"}, remaining, (v.count == 0) ? 0 : int'(v.count) - npre);
            check({name, "_ready"}, cfg_ready, 1);
        end
        check({name, "_missing"}, pulse_q.size(), 0);
        pulse_q.delete();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check({name, "_stopped"}, busy, 0);
    endtask

    initial begin
        v_def    = '{1'b0, 5'd0,  8'd0, 17, 1, '{16, 0, 0, 0, 0, 0, 0, 0}, -1};
        v_shadow = '{1'b0, 5'd0,  8'd1,  4, 1, '{1, 0, 0, 0, 0, 0, 0, 0}, 2};
        vecs[0]  = '{1'b1, 5'd4,  8'd0, 18, 4, '{4, 8, 12, 16, 0, 0, 0, 0}, -1};
        vecs[1]  = '{1'b1, 5'd3,  8'd0, 33, 6, '{6, 11, 16, 22, 27, 32, 0, 0}, -1};
        vecs[2]  = '{1'b1, 5'd8,  8'd3, 12, 3, '{2, 4, 6, 0, 0, 0, 0, 0}, 7};
        vecs[3]  = '{1'b1, 5'd16, 8'd2,  6, 2, '{1, 2, 0, 0, 0, 0, 0, 0}, 3};
        vecs[4]  = '{1'b1, 5'd5,  8'd0, 17, 5, '{4, 7, 10, 13, 16, 0, 0, 0}, -1};
        vecs[5]  = '{1'b1, 5'd0,  8'd0, 20, 0, '{0, 0, 0, 0, 0, 0, 0, 0}, -1};
        vecs[6]  = '{1'b1, 5'd1,  8'd1, 20, 1, '{16, 0, 0, 0, 0, 0, 0, 0}, 17};

        // Reset state
        repeat (2) tick();
        rst_n = 1'b1;
        check("rst_pulse", pulse, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rem", remaining, 0);
        check("rst_ready", cfg_ready, 1);
        tick();
        check("rst_idle", busy, 0);

        // Default increment after reset, then the vector table
        run_vec("def_incr", v_def);
        for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Rate change while running: old period completes, then new spacing
        cfg_valid = 1'b1; cfg_incr = 5'd2; cfg_count = 8'd0; start = 1'b1;
        foreach (vecs[0].off[i]) if (i < 5) pulse_q.push_back(cyc + 1 + 8 + 2 * i);
        for (int k = 0; k <= 16; k++) begin
            tick();
            if (k == 0) begin start = 1'b0; cfg_valid = 1'b0; end
            check("sh_busy", busy, 1);
            if (k == 3) begin
                check("sh_ready_empty", cfg_ready, 1);
                cfg_valid = 1'b1; cfg_incr = 5'd8;
            end
            if (k == 4) begin
                check("sh_ready_full", cfg_ready, 0);
                cfg_incr = 5'd16;
            end
            if (k == 6) begin
                check("sh_ready_full2", cfg_ready, 0);
                cfg_valid = 1'b0;
            end
            if (k == 9) check("sh_ready_free", cfg_ready, 1);
        end
        check("sh_missing", pulse_q.size(), 0);
        pulse_q.delete();
        stop = 1'b1; tick(); stop = 1'b0;
        check("sh_stopped", busy, 0);

        // Start and stop together: stop wins, no pulse
        cfg_valid = 1'b1; cfg_incr = 5'd16; cfg_count = 8'd0; start = 1'b1; stop = 1'b1;
        tick();
        cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
        check("ss_busy", busy, 0);
        repeat (3) begin
            tick();
            check("ss_idle", busy, 0);
            check("ss_pulse", pulse, 0);
        end

        // Stop mid-burst with a pending shadow: no done, shadow applied in IDLE
        cfg_valid = 1'b1; cfg_incr = 5'd0; cfg_count = 8'd4; start = 1'b1;
        tick();
        start = 1'b0; cfg_valid = 1'b0;
        check("sm_busy", busy, 1);
        check("sm_rem", remaining, 4);
        tick();
        cfg_valid = 1'b1; cfg_incr = 5'd16; cfg_count = 8'd1;
        tick();
        cfg_valid = 1'b0;
        check("sm_ready_full", cfg_ready, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("sm_stop_busy", busy, 0);
        check("sm_stop_done", done, 0);
        check("sm_stop_rem", remaining, 0);
        check("sm_stop_ready", cfg_ready, 1);
        repeat (2) begin
            tick();
            check("sm_no_done", done, 0);
        end
        run_vec("shadow_apply", v_shadow);

        // Asynchronous reset mid-burst
        cfg_valid = 1'b1; cfg_incr = 5'd16; cfg_count = 8'd9; start = 1'b1;
        for (int i = 1; i <= 3; i++) pulse_q.push_back(cyc + 1 + i);
        tick();
        start = 1'b0; cfg_valid = 1'b0;
        repeat (3) tick();
        check("ar_rem_before", remaining, 7);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_pulse", pulse, 0);
        check("ar_busy", busy, 0);
        check("ar_rem", remaining, 0);
        check("ar_done", done, 0);
        check("ar_ready", cfg_ready, 1);
        check("ar_missing", pulse_q.size(), 0);
        pulse_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        check("ar_after_busy", busy, 0);

`ifdef PULSE_CTRL_AUTORELOAD_EN
        // Auto-reload: done every 4 cycles, pulses uninterrupted every 2
        auto_i = 1'b1;
        cfg_valid = 1'b1; cfg_incr = 5'd8; cfg_count = 8'd2; start = 1'b1;
        for (int p = 2; p <= 14; p += 2) pulse_q.push_back(cyc + 1 + p);
        for (int k = 0; k <= 14; k++) begin
            tick();
            if (k == 0) begin start = 1'b0; cfg_valid = 1'b0; end
            check("au_busy", busy, 1);
            check("au_done", done, (k >= 5 && ((k - 5) % 4) == 0));
            check("au_rem", remaining, (k == 0) ? 2 : 2 - (((k - 1) / 2) % 2));
        end
        check("au_missing", pulse_q.size(), 0);
        pulse_q.delete();
        stop = 1'b1; tick(); stop = 1'b0; auto_i = 1'b0;
        check("au_stopped", busy, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
